// File: rtl/led_share_ctrl.sv
// led_share_ctrl: shares one LED between NUM_REQ requesters and plays the granted requester's pattern.
// Ports: clk_buf clock, rst sync active-high reset, req per-requester level request,
//        pat 4-bit pattern code per requester ([3:2] mode, [1:0] n), gnt one-hot grant,
//        busy = |gnt, led registered LED drive.
// Define LED_SHARE_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module led_share_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 32
) (
  input  logic                 clk_buf,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] pat,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 led
);
`ifdef LED_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [IW-1:0] g, g_d, win, ptr;
  logic [1:0] mode, mode_d, n, n_d;
  logic [3:0] ph, ph_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic led_d, tick, last, other;
  function automatic logic [3:0] period(input logic [1:0] m, input logic [1:0] k);
    logic [3:0] tw;
    tw = {1'b0, k, 1'b0} + 4'd2;
    return m[1] ? (m[0] ? tw + 4'd2 : tw) : 4'd1;
  endfunction
  function automatic logic led_at(input logic [1:0] m, input logic [1:0] k, input logic [3:0] p);
    return m == 2'd0 ? 1'b0 :
           m == 2'd1 ? 1'b1 :
           m == 2'd2 ? (p <= {2'b0, k}) :
                       (p[3:1] <= {1'b0, k}) && !p[0];
  endfunction
  // fixed priority searches from 0; round-robin starts one past the last grant
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[((RR ? int'(ptr) + 1 : 0) + k) % NUM_REQ]) win = IW'(((RR ? int'(ptr) + 1 : 0) + k) % NUM_REQ);
  end
  always_comb begin
    other = 1'b0;
    for (int j = 0; j < NUM_REQ; j++)
      if (req[j] && (RR ? j != int'(g) : j < int'(g))) other = 1'b1;
  end
  assign tick = state == RUN && cnt == CNT_W'(TICK_DIV - 1);
  assign last = ph == period(mode, n) - 4'd1;
  always_comb begin
    state_d = state;
    g_d = g;
    mode_d = mode;
    n_d = n;
    ph_d = ph;
    cnt_d = '0;
    if (state == IDLE) begin
      if (|req) begin
        state_d = RUN;
        g_d = win;
        {mode_d, n_d} = pat[4*int'(win) +: 4];
      end
    end else begin
      cnt_d = tick ? '0 : cnt + 1'b1;
      ph_d = tick ? (last ? 4'd0 : ph + 4'd1) : ph;
      if (tick && last) begin
        if (!req[g] || other) state_d = IDLE;
        else {mode_d, n_d} = pat[4*int'(g) +: 4];
      end
    end
    led_d = state_d == RUN && led_at(mode_d, n_d, ph_d);
  end
  always_ff @(posedge clk_buf) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      mode <= '0;
      n <= '0;
      ph <= '0;
      cnt <= '0;
      led <= 1'b0;
      ptr <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_d;
      g <= g_d;
      mode <= mode_d;
      n <= n_d;
      ph <= ph_d;
      cnt <= cnt_d;
      led <= led_d;
      ptr <= (state == IDLE && |req) ? win : ptr;
    end
  end
  assign gnt = state == RUN ? NUM_REQ'(1) << g : '0;
  assign busy = |gnt;
endmodule

// File: tb/tb_led_share_ctrl.sv
// tb_led_share_ctrl: directed literal checks plus randomized run against a time-based model.
module tb_led_share_ctrl;
  localparam int N = 4;
  localparam int TD = 4;
`ifdef LED_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk_buf = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [4*N-1:0] pat = '0;
  logic [N-1:0] gnt;
  logic busy, led;
  int checks = 0;
  int errors = 0;
  int mg = -1, mmode = 0, mn = 0, mt = 0, mptr = N - 1;
  logic [N-1:0] exp_gnt = '0;
  logic exp_led = 1'b0;
  bit mvalid = 1'b0;
  led_share_ctrl #(.NUM_REQ(N), .TICK_DIV(TD), .CNT_W(8)) dut (
    .clk_buf(clk_buf), .rst(rst), .req(req), .pat(pat), .gnt(gnt), .busy(busy), .led(led)
  );
  always #5 clk_buf = ~clk_buf;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int mperiod(input int m, input int k);
    return m < 2 ? 1 : (m == 2 ? 2 * (k + 1) : 2 * (k + 1) + 2);
  endfunction
  function automatic bit mled(input int m, input int k, input int t);
    int ti;
    ti = t / TD;
    if (m == 0) return 1'b0;
    if (m == 1) return 1'b1;
    if (m == 2) return ti < k + 1;
    return ti < 2 * (k + 1) && ti % 2 == 0;
  endfunction
  task automatic latch(input int idx);
    logic [3:0] f;
    f = pat[4*idx +: 4];
    mmode = int'(f[3:2]);
    mn = int'(f[1:0]);
    mt = 0;
  endtask
  task automatic model_step();
    bit rel;
    int idx;
    if (rst) begin
      mg = -1;
      mt = 0;
      mptr = N - 1;
    end else if (mg < 0) begin
      for (int k = 1; k <= N; k++) begin
        idx = RR ? (mptr + k) % N : k - 1;
        if (mg < 0 && req[idx]) mg = idx;
      end
      if (mg >= 0) begin
        mptr = mg;
        latch(mg);
      end
    end else begin
      mt++;
      if (mt == TD * mperiod(mmode, mn)) begin
        rel = !req[mg];
        for (int j = 0; j < N; j++) if (req[j] && (RR ? j != mg : j < mg)) rel = 1'b1;
        if (rel) mg = -1;
        else latch(mg);
      end
    end
    exp_gnt = mg < 0 ? '0 : N'(1 << mg);
    exp_led = mg >= 0 && mled(mmode, mn, mt);
    mvalid = 1'b1;
  endtask
  task automatic step();
    @(posedge clk_buf);
    model_step();
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask
  always @(negedge clk_buf) begin
    if (mvalid) begin
      chk("model_gnt", 32'(gnt), 32'(exp_gnt));
      chk("model_busy", 32'(busy), 32'(|exp_gnt));
      chk("model_led", 32'(led), 32'(exp_led));
    end
  end
  initial begin
    rst = 1'b1;
    req = 4'hF;
    pat = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_led", 32'(led), 32'h0);
    end
    rst = 1'b0;
    step();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_led", 32'(led), 32'h1);
    do_reset();
    pat = 16'h0400;
    req = 4'b0100;
    step();
    chk("solid_gnt", 32'(gnt), 32'h4);
    chk("solid_led", 32'(led), 32'h1);
    req = '0;
    repeat (3) step();
    chk("solid_hold", 32'(gnt), 32'h4);
    step();
    chk("solid_rel_gnt", 32'(gnt), 32'h0);
    chk("solid_rel_led", 32'(led), 32'h0);
    do_reset();
    pat = 16'h0090;
    req = 4'b0010;
    step();
    for (int c = 0; c < 48; c++) begin
      chk("blink_led", 32'(led), 32'((c % 16) < 8));
      chk("blink_gnt", 32'(gnt), 32'h2);
      step();
    end
    do_reset();
    pat = 16'hE000;
    req = 4'b1000;
    step();
    for (int c = 0; c < 64; c++) begin
      chk("burst_led", 32'(led), 32'(((c % 32) / 4) < 6 && ((c % 32) / 4) % 2 == 0));
      chk("burst_gnt", 32'(gnt), 32'h8);
      step();
    end
    do_reset();
    pat = 16'hB004;
    req = 4'b1000;
    step();
    for (int c = 0; c < 32; c++) begin
      chk("pre_hold", 32'(gnt), 32'h8);
      if (c == 5) req = 4'b1001;
      step();
    end
    chk("pre_idle_gnt", 32'(gnt), 32'h0);
    chk("pre_idle_led", 32'(led), 32'h0);
    step();
    chk("pre_new_gnt", 32'(gnt), 32'h1);
    do_reset();
    pat = 16'h4444;
    req = 4'hF;
    step();
    chk("arb_c0", 32'(gnt), 32'h1);
    repeat (4) step();
    chk("arb_c4", 32'(gnt), RR ? 32'h0 : 32'h1);
    step();
    chk("arb_c5", 32'(gnt), RR ? 32'h2 : 32'h1);
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(299) == 0;
      if ($urandom_range(7) == 0) req = N'($urandom);
      if ($urandom_range(3) == 0) pat = (4*N)'($urandom);
      step();
    end
    rst = 1'b0;
    step();
    @(negedge clk_buf);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
